// File: rtl/pcie_cq_type_monitor.sv
// rtl/pcie_cq_type_monitor.sv - CQ pass-through monitor counting requests per type with snapshot
module pcie_cq_type_monitor #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_TUSER_WIDTH = 228,
   parameter int CNT_WIDTH        = 8,
   parameter int DW_CNT_WIDTH     = 32,
   parameter int SATURATE         = 1,
   parameter int SOP_MODE         = 0,
   parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   output logic                          s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]    m_axis_tkeep,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   input  logic                          m_axis_tready,
   input  logic                          snap_req,
   input  logic                          clear_on_snap,
   output logic [16*CNT_WIDTH-1:0]       cnt_type,
   output logic [DW_CNT_WIDTH-1:0]       cnt_dw,
   output logic [CNT_WIDTH-1:0]          cnt_frame_err,
   output logic [15:0]                   ovf,
   output logic [16*CNT_WIDTH-1:0]       snap_type,
   output logic [DW_CNT_WIDTH-1:0]       snap_dw,
   output logic                          snap_valid
);

   localparam logic STATE_IDLE   = 1'b0;
   localparam logic STATE_IN_PKT = 1'b1;

   logic                        r_state;
   logic                        w_state_nxt;
   logic                        w_in_idle;
   logic                        w_accept;
   logic                        w_sop;
   logic                        w_frame_err_evt;
   logic                        w_clear;
   logic [3:0]                  w_type;
   logic [10:0]                 w_dw;
   logic [16*CNT_WIDTH-1:0]     r_cnt_type;
   logic [16*CNT_WIDTH-1:0]     w_cnt_type_nxt;
   logic [15:0]                 r_ovf;
   logic [15:0]                 w_ovf_nxt;
   logic [DW_CNT_WIDTH-1:0]     r_cnt_dw;
   logic [DW_CNT_WIDTH-1:0]     w_dw_base;
   logic [DW_CNT_WIDTH:0]       w_dw_sum;
   logic [DW_CNT_WIDTH-1:0]     w_cnt_dw_nxt;
   logic [CNT_WIDTH-1:0]        r_cnt_frame_err;
   logic [CNT_WIDTH-1:0]        w_fe_base;
   logic [CNT_WIDTH-1:0]        w_cnt_frame_err_nxt;
   logic [16*CNT_WIDTH-1:0]     r_snap_type;
   logic [DW_CNT_WIDTH-1:0]     r_snap_dw;
   logic                        r_snap_valid;

   // Counter step: all-ones either holds or wraps to zero
   function automatic logic [CNT_WIDTH-1:0] f_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v)
         f_inc = (SATURATE != 0) ? v : '0;
      else
         f_inc = v + CNT_WIDTH'(1);
   endfunction

   // The stream itself is never touched: monitoring must not add latency or backpressure
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tvalid = s_axis_tvalid;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tuser  = s_axis_tuser;
   assign s_axis_tready = m_axis_tready;

   assign w_accept = s_axis_tvalid && m_axis_tready;
   assign w_type   = s_axis_tdata[78:75];
   assign w_dw     = s_axis_tdata[74:64];
   assign w_clear  = snap_req && clear_on_snap;

   // FSM state register: tracks whether we are inside a multi-beat packet
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= STATE_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // FSM next state: only accepted beats move the framing
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept)
         w_state_nxt = s_axis_tlast ? STATE_IDLE : STATE_IN_PKT;
   end

   // FSM outputs: SOP source selection and framing-error detection
   always_comb begin
      w_in_idle = (r_state == STATE_IDLE);
      if (SOP_MODE != 0)
         w_sop = w_accept && w_in_idle;
      else
         w_sop = w_accept && (s_axis_tuser[81:80] != 2'b00);
      w_frame_err_evt = (SOP_MODE == 0) && w_accept && (w_in_idle ? !w_sop : w_sop);
   end

   // Per-type next values; a clearing snapshot starts the new interval from zero
   always_comb begin
      w_cnt_type_nxt = w_clear ? '0 : r_cnt_type;
      w_ovf_nxt      = w_clear ? '0 : r_ovf;
      for (int i = 0; i < 16; i++) begin
         if (w_sop && (w_type == 4'(i))) begin
            if (&w_cnt_type_nxt[i*CNT_WIDTH +: CNT_WIDTH])
               w_ovf_nxt[i] = 1'b1;
            w_cnt_type_nxt[i*CNT_WIDTH +: CNT_WIDTH] = f_inc(w_cnt_type_nxt[i*CNT_WIDTH +: CNT_WIDTH]);
         end
      end
   end

   // Dword accumulator and framing-error next values
   always_comb begin
      w_dw_base = w_clear ? '0 : r_cnt_dw;
      w_dw_sum  = {1'b0, w_dw_base} + (DW_CNT_WIDTH+1)'(w_dw);
      if (!w_sop)
         w_cnt_dw_nxt = w_dw_base;
      else if (w_dw_sum[DW_CNT_WIDTH])
         w_cnt_dw_nxt = (SATURATE != 0) ? '1 : w_dw_sum[DW_CNT_WIDTH-1:0];
      else
         w_cnt_dw_nxt = w_dw_sum[DW_CNT_WIDTH-1:0];
      w_fe_base           = w_clear ? '0 : r_cnt_frame_err;
      w_cnt_frame_err_nxt = w_frame_err_evt ? f_inc(w_fe_base) : w_fe_base;
   end

   // Live counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt_type      <= '0;
         r_ovf           <= '0;
         r_cnt_dw        <= '0;
         r_cnt_frame_err <= '0;
      end else begin
         r_cnt_type      <= w_cnt_type_nxt;
         r_ovf           <= w_ovf_nxt;
         r_cnt_dw        <= w_cnt_dw_nxt;
         r_cnt_frame_err <= w_cnt_frame_err_nxt;
      end
   end

   // Snapshot captures the values as they stood before this cycle's update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_snap_type  <= '0;
         r_snap_dw    <= '0;
         r_snap_valid <= 1'b0;
      end else begin
         r_snap_valid <= snap_req;
         if (snap_req) begin
            r_snap_type <= r_cnt_type;
            r_snap_dw   <= r_cnt_dw;
         end
      end
   end

   assign cnt_type      = r_cnt_type;
   assign cnt_dw        = r_cnt_dw;
   assign cnt_frame_err = r_cnt_frame_err;
   assign ovf           = r_ovf;
   assign snap_type     = r_snap_type;
   assign snap_dw       = r_snap_dw;
   assign snap_valid    = r_snap_valid;

endmodule

// File: doc/pcie_cq_type_monitor.md
PCIE_CQ_TYPE_MONITOR -- requirements
Module: pcie_cq_type_monitor

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, 512, CQ data width in bits (min 128).
REQ-002 SHALL have parameter AXIS_TUSER_WIDTH, 228, CQ tuser width in bits.
REQ-003 SHALL have parameter CNT_WIDTH, 8, width of each per-type counter (2..32).
REQ-004 SHALL have parameter DW_CNT_WIDTH, 32, width of the payload dword accumulator.
REQ-005 SHALL have parameter SATURATE, 1, 1 = counters hold at all-ones, 0 = counters wrap.
REQ-006 SHALL have parameter SOP_MODE, 0, 0 = SOP from tuser[81:80] != 0, 1 = SOP from framing FSM.
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports s_axis_tdata/tkeep/tvalid/tlast/tuser, input, AXIS widths, CQ slave stream.
REQ-010 SHALL have port s_axis_tready, output, 1, equal to m_axis_tready.
REQ-011 SHALL have ports m_axis_tdata/tkeep/tvalid/tlast/tuser, output, AXIS widths, equal to the s_axis counterparts.
REQ-012 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-013 SHALL have port snap_req, input, 1, single-cycle snapshot request.
REQ-014 SHALL have port clear_on_snap, input, 1, sampled with snap_req: 1 = clear live counters.
REQ-015 SHALL have port cnt_type, output, 16*CNT_WIDTH, live per-type counters; type i at [i*CNT_WIDTH +: CNT_WIDTH].
REQ-016 SHALL have port cnt_dw, output, DW_CNT_WIDTH, live accumulated request dword count.
REQ-017 SHALL have port cnt_frame_err, output, CNT_WIDTH, live framing-error counter.
REQ-018 SHALL have port ovf, output, 16, sticky per-type overflow/saturation flags.
REQ-019 SHALL have ports snap_type / snap_dw, output, 16*CNT_WIDTH / DW_CNT_WIDTH, captured copies.
REQ-020 SHALL have port snap_valid, output, 1, one-cycle pulse when a snapshot is loaded.

Function
REQ-021 Pass-through SHALL be purely combinational, zero latency, with no dependence on counter state.
REQ-022 Beat accepted SHALL mean s_axis_tvalid && m_axis_tready; nothing SHALL be counted otherwise.
REQ-023 Framing FSM SHALL have states IDLE and IN_PKT: IDLE->IN_PKT on accepted beat with tlast=0; IN_PKT->IDLE on accepted beat with tlast=1; all other cases hold.
REQ-024 With SOP_MODE=1, SOP SHALL be an accepted beat while in IDLE.
REQ-025 With SOP_MODE=0, SOP SHALL be an accepted beat with tuser[81:80] != 2'b00.
REQ-026 On SOP, counter index tdata[78:75] SHALL increment by 1 one cycle after the accepting edge.
REQ-027 On SOP, cnt_dw SHALL add the zero-extended tdata[74:64] (dword count); value 0 SHALL add 0.
REQ-028 With SOP_MODE=0, cnt_frame_err SHALL increment on SOP while IN_PKT, or on a non-SOP accepted beat while IDLE.
REQ-029 SATURATE=1: a counter at all-ones SHALL hold, and the matching ovf bit SHALL set on each further event.
REQ-030 SATURATE=0: a counter at all-ones SHALL wrap to 0, and the matching ovf bit SHALL set.
REQ-031 ovf bits SHALL remain set until reset or a snapshot with clear_on_snap=1.
REQ-032 cnt_dw SHALL saturate or wrap per SATURATE; it has no ovf bit.
REQ-033 On snap_req, snap_type/snap_dw SHALL load the pre-update live values, and snap_valid SHALL pulse on the next cycle.
REQ-034 On snap_req with clear_on_snap=1, live counters and ovf SHALL clear; a same-cycle event SHALL load 1 (or the dword count) into the new interval.
REQ-035 On snap_req with clear_on_snap=0, live counters SHALL continue, and a same-cycle event SHALL increment normally.
REQ-036 Back-to-back snap_req SHALL be honoured every cycle.

Reset
REQ-037 rst=0 SHALL asynchronously force all counters, cnt_dw, cnt_frame_err, ovf, snap_type, snap_dw and snap_valid to 0, and the FSM to IDLE.
REQ-038 Reset deassertion SHALL take effect on the next clk edge; a packet in flight at reset SHALL be discarded, and its remaining beats SHALL be treated per REQ-023..028.

Verification
REQ-039 Three 1-beat SOPs, types 0,1,1, dword counts 4,1,1 -> cnt_type[0]=1, cnt_type[1]=2, cnt_dw=6.
REQ-040 CNT_WIDTH=4, SATURATE=1, twenty type-0xA SOPs -> counter=15, ovf[10]=1; with SATURATE=0 -> counter=4, ovf[10]=1.
REQ-041 4-beat packet with m_axis_tready toggling each cycle, SOP_MODE=1 -> exactly one count, FSM returns to IDLE after the tlast beat.
REQ-042 snap_req+clear_on_snap=1 in the same cycle as a type-1 SOP with live count 7 -> snap_type[1]=7, live=1, snap_valid pulses one cycle.
REQ-043 SOP_MODE=0, SOP beat with tlast=0 followed by a second SOP -> cnt_frame_err=1, both types counted.
REQ-044 Assert rst mid-packet with counters nonzero -> all outputs 0 immediately, before the next clk edge.
